// File: rtl/rs_encoder_if.sv
// ----------------------------------------------------------------------------
// rs_encoder_if
//   Handshake bundle between the RS(7,3) encoder and its neighbours.
//   slave  : encoder side (accepts messages, produces codewords)
//   master : environment side (supplies messages, consumes codewords)
//   Signals:
//     msg_valid / msg_ready / msg         message input handshake, 9-bit msg
//     cw_valid  / cw_ready  / codeword    codeword output handshake, 21-bit cw
//     busy                                encoder is in SHIFT or DONE
// ----------------------------------------------------------------------------
interface rs_encoder_if #(
    parameter int SYM_W = 3,
    parameter int K_SYM = 3,
    parameter int N_SYM = 7
);
    logic                     msg_valid;
    logic                     msg_ready;
    logic [K_SYM*SYM_W-1:0]   msg;
    logic                     cw_valid;
    logic                     cw_ready;
    logic [N_SYM*SYM_W-1:0]   codeword;
    logic                     busy;

    modport slave (
        input  msg_valid,
        input  msg,
        input  cw_ready,
        output msg_ready,
        output cw_valid,
        output codeword,
        output busy
    );

    modport master (
        output msg_valid,
        output msg,
        output cw_ready,
        input  msg_ready,
        input  cw_valid,
        input  codeword,
        input  busy
    );
endinterface

// File: rtl/rs_encoder.sv
// ----------------------------------------------------------------------------
// rs_encoder
//   Systematic RS(7,3) encoder over GF(8) (primitive poly x^3+x+1).
//   Message symbols m2, m1, m0 are shifted one per cycle through a 4-stage
//   LFSR implementing division by g(x) = x^4 + 3x^3 + x^2 + 2x + 3; the
//   remainder becomes parity c3..c0. Codeword = {msg, c3, c2, c1, c0}.
//   Ports:
//     clk    in  single clock, posedge
//     reset  in  synchronous, active-high
//     bus    slave modport of rs_encoder_if (msg/codeword handshakes, busy)
// ----------------------------------------------------------------------------
module rs_encoder #(
    parameter int SYM_W = 3,
    parameter int K_SYM = 3,
    parameter int N_SYM = 7
) (
    input  logic          clk,
    input  logic          reset,
    rs_encoder_if.slave   bus
);
    localparam int MSG_W = K_SYM * SYM_W;
    localparam int CW_W  = N_SYM * SYM_W;
    localparam int NPAR  = N_SYM - K_SYM;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Multiply by alpha (x): shift left, fold x^3 back as x+1.
    function automatic logic [2:0] gf_mul2(input logic [2:0] a);
        gf_mul2 = {a[1], a[0] ^ a[2], a[2]};
    endfunction

    // Multiply by alpha^3 = alpha + 1: (x * a) xor a.
    function automatic logic [2:0] gf_mul3(input logic [2:0] a);
        gf_mul3 = {a[1] ^ a[2], a[0] ^ a[2] ^ a[1], a[2] ^ a[0]};
    endfunction

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [MSG_W-1:0]              r_msg;
    logic [NPAR-1:0][SYM_W-1:0]    r_par;
    logic [1:0]                    r_cnt;
    logic [CW_W-1:0]               r_codeword;

    logic [SYM_W-1:0]              w_sym;
    logic [SYM_W-1:0]              w_fb;
    logic [NPAR-1:0][SYM_W-1:0]    w_par_nxt;

    // Highest-degree symbol first.
    always_comb begin
        w_sym = '0;
        case (r_cnt)
            2'd0:    w_sym = r_msg[8:6];
            2'd1:    w_sym = r_msg[5:3];
            default: w_sym = r_msg[2:0];
        endcase
    end

    // One LFSR step; g2 = 1 so that tap is a plain wire.
    always_comb begin
        w_fb         = w_sym ^ r_par[3];
        w_par_nxt    = '0;
        w_par_nxt[3] = r_par[2] ^ gf_mul3(w_fb);
        w_par_nxt[2] = r_par[1] ^ w_fb;
        w_par_nxt[1] = r_par[0] ^ gf_mul2(w_fb);
        w_par_nxt[0] = gf_mul3(w_fb);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.msg_valid)   w_state_nxt = SHIFT;
            SHIFT:   if (r_cnt == 2'd2)   w_state_nxt = DONE;
            DONE:    if (bus.cw_ready)    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.msg_ready = (r_state == IDLE);
        bus.cw_valid  = (r_state == DONE);
        bus.busy      = (r_state != IDLE);
        bus.codeword  = r_codeword;
    end

    // Datapath: message latch, LFSR, symbol counter, codeword register.
    // The codeword is captured from the LFSR next value on the final step
    // so that it is ready in the same edge that enters DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_msg      <= '0;
            r_par      <= '0;
            r_cnt      <= '0;
            r_codeword <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.msg_valid) begin
                        r_msg <= bus.msg;
                        r_par <= '0;
                        r_cnt <= '0;
                    end
                end
                SHIFT: begin
                    r_par <= w_par_nxt;
                    if (r_cnt == 2'd2) begin
                        r_cnt      <= '0;
                        r_codeword <= {r_msg, w_par_nxt};
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rs_encoder.sv
module tb_rs_encoder;
    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    rs_encoder_if #(.SYM_W(3), .K_SYM(3), .N_SYM(7)) bus ();

    rs_encoder #(.SYM_W(3), .K_SYM(3), .N_SYM(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Generic shift-and-add GF(8) multiply for syndrome evaluation.
    function automatic logic [2:0] gmul(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] p;
        logic [2:0] t;
        p = 3'd0;
        t = a;
        for (int i = 0; i < 3; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[1], t[0] ^ t[2], t[2]};
        end
        return p;
    endfunction

    function automatic logic [2:0] syndrome(input logic [20:0] cw, input logic [2:0] root);
        logic [2:0] acc;
        acc = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            acc = gmul(acc, root) ^ cw[i*3 +: 3];
        end
        return acc;
    endfunction

    // Offer m, check accept, 3-cycle latency and stability for 'hold' cycles,
    // then consume the codeword and check return to IDLE.
    task automatic encode(input logic [8:0] m, input int hold, output logic [20:0] cw);
        int lat;
        int wait_cnt;
        logic [20:0] first;
        bus.cw_ready  = 1'b0;
        bus.msg       = m;
        bus.msg_valid = 1'b1;
        wait_cnt = 0;
        while (!bus.msg_ready && wait_cnt < 20) begin
            tick();
            wait_cnt++;
        end
        check("accept_ready", {31'd0, bus.msg_ready}, 32'd1);
        tick();
        bus.msg_valid = 1'b0;
        bus.msg       = ~m;
        check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
        check("ready_low_shift", {31'd0, bus.msg_ready}, 32'd0);
        lat = 0;
        while (!bus.cw_valid && lat < 10) begin
            tick();
            lat++;
        end
        check("latency", lat, 32'd3);
        first = bus.codeword;
        cw = first;
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_valid", {31'd0, bus.cw_valid}, 32'd1);
            check("hold_cw", {11'd0, bus.codeword}, {11'd0, first});
            check("hold_ready_low", {31'd0, bus.msg_ready}, 32'd0);
        end
        bus.cw_ready = 1'b1;
        tick();
        bus.cw_ready = 1'b0;
        check("post_valid_low", {31'd0, bus.cw_valid}, 32'd0);
        check("post_ready_high", {31'd0, bus.msg_ready}, 32'd1);
        check("post_cw_retained", {11'd0, bus.codeword}, {11'd0, first});
    endtask

    initial begin
        logic [20:0] cw;
        logic [8:0]  m;
        logic [2:0]  roots [4];
        int          cnt;
        roots[0] = 3'd2; roots[1] = 3'd4; roots[2] = 3'd3; roots[3] = 3'd6;

        bus.msg_valid = 1'b0;
        bus.msg       = 9'd0;
        bus.cw_ready  = 1'b0;
        reset         = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_msg_ready", {31'd0, bus.msg_ready}, 32'd1);
        check("rst_cw_valid", {31'd0, bus.cw_valid}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_codeword", {11'd0, bus.codeword}, 32'd0);

        encode(9'h000, 0, cw);
        check("cw_000", {11'd0, cw}, 32'h000000);
        encode(9'h001, 1, cw);
        check("cw_001", {11'd0, cw}, 32'h001653);
        encode(9'h040, 10, cw);
        check("cw_040", {11'd0, cw}, 32'h040C77);
        encode(9'h008, 0, cw);
        check("cw_008", {11'd0, cw}, 32'h00886D);

        // cw_ready held high: DONE lasts exactly one cycle.
        bus.cw_ready  = 1'b1;
        bus.msg       = 9'h001;
        bus.msg_valid = 1'b1;
        tick();
        bus.msg_valid = 1'b0;
        cnt = 0;
        while (!bus.cw_valid && cnt < 10) begin
            tick();
            cnt++;
        end
        check("rdyhi_latency", cnt, 32'd3);
        check("rdyhi_cw", {11'd0, bus.codeword}, 32'h001653);
        tick();
        check("rdyhi_one_cycle", {31'd0, bus.cw_valid}, 32'd0);
        check("rdyhi_idle", {31'd0, bus.msg_ready}, 32'd1);
        bus.cw_ready = 1'b0;

        // Reset while SHIFT has cnt=1: message discarded.
        bus.msg       = 9'h1FF;
        bus.msg_valid = 1'b1;
        tick();
        bus.msg_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_ready", {31'd0, bus.msg_ready}, 32'd1);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_codeword", {11'd0, bus.codeword}, 32'd0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.cw_valid) cnt++;
        end
        check("midrst_no_output", cnt, 32'd0);
        encode(9'h041, 0, cw);
        check("cw_041", {11'd0, cw}, 32'h041A24);

        // Pseudo-random messages: systematic field and zero syndromes at a^1..a^4.
        for (int n = 0; n < 30; n++) begin
            m = 9'($urandom_range(511, 0));
            encode(m, int'($urandom_range(2, 0)), cw);
            check("rnd_msg_field", {23'd0, cw[20:12]}, {23'd0, m});
            for (int j = 0; j < 4; j++) begin
                check("rnd_syndrome", {29'd0, syndrome(cw, roots[j])}, 32'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
